// File: rtl/time_frame_builder.sv
// Converts an h/m/s snapshot to BCD with a serial double-dabble engine and
// commits a complete 6x5 LED frame in one cycle so the display never tears.
module time_frame_builder #(
    parameter bit edge_start   = 1'b1,
    parameter bit show_seconds = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_tick,
    input  logic [4:0]  hours,
    input  logic [5:0]  minutes,
    input  logic [5:0]  seconds,
    output logic [29:0] pixels,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic         s_tick_q;
    logic         pending;
    logic [5:0]   snap_h;
    logic [5:0]   snap_m;
    logic [5:0]   snap_s;
    logic [1:0]   field;
    logic [2:0]   shift_cnt;
    logic [7:0]   bcd;
    logic [29:0]  staging;

    logic         start;
    logic         load;
    logic         last_shift;
    logic [5:0]   cur;
    logic [13:0]  step;

    // One double-dabble iteration: {tens, ones, binary} -> adjusted and shifted
    function automatic logic [13:0] dd_step(input logic [13:0] v);
        logic [13:0] t;
        t = v;
        if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
        if (t[9:6] >= 4'd5)   t[9:6]   = t[9:6] + 4'd3;
        return t << 1;
    endfunction

    assign start      = edge_start ? (s_tick & ~s_tick_q) : s_tick;
    assign last_shift = (shift_cnt == 3'd5);
    assign busy       = (state != IDLE);

    always_comb begin
        case (field)
            2'd0:    cur = snap_h;
            2'd1:    cur = snap_m;
            default: cur = snap_s;
        endcase
    end

    assign step = dd_step({bcd, cur});

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CONV;
                    load     = 1'b1;
                end
            end
            CONV: begin
                if (last_shift && field == 2'd2) state_nx = COMMIT;
            end
            COMMIT: begin
                if (pending || start) begin
                    state_nx = CONV;
                    load     = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pixels     <= '0;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            s_tick_q   <= 1'b1;
            snap_h     <= '0;
            snap_m     <= '0;
            snap_s     <= '0;
            field      <= '0;
            shift_cnt  <= '0;
            bcd        <= '0;
            staging    <= '0;
        end else begin
            state      <= state_nx;
            s_tick_q   <= s_tick;
            frame_done <= (state == COMMIT);

            if (state == COMMIT) begin
                pixels <= show_seconds ? staging : {10'b0, staging[19:0]};
            end

            // A tick consumed by the COMMIT restart may itself queue another
            if (state == COMMIT)
                pending <= pending & start;
            else if (state != IDLE && start)
                pending <= 1'b1;

            if (load) begin
                snap_h    <= {1'b0, hours};
                snap_m    <= minutes;
                snap_s    <= seconds;
                field     <= 2'd0;
                shift_cnt <= 3'd0;
                bcd       <= '0;
                staging   <= '0;
            end else if (state == CONV) begin
                case (field)
                    2'd0:    snap_h <= step[5:0];
                    2'd1:    snap_m <= step[5:0];
                    default: snap_s <= step[5:0];
                endcase
                if (last_shift) begin
                    case (field)
                        2'd0: begin
                            staging[1:0] <= step[11:10];
                            staging[8:5] <= step[9:6];
                        end
                        2'd1: begin
                            staging[12:10] <= step[12:10];
                            staging[18:15] <= step[9:6];
                        end
                        default: begin
                            staging[22:20] <= step[12:10];
                            staging[28:25] <= step[9:6];
                        end
                    endcase
                    field     <= field + 2'd1;
                    shift_cnt <= 3'd0;
                    bcd       <= '0;
                end else begin
                    shift_cnt <= shift_cnt + 3'd1;
                    bcd       <= step[13:6];
                end
            end
        end
    end

endmodule

// File: tb/tb_time_frame_builder.sv
// Directed bench for time_frame_builder: reset, conversion values, queuing,
// input freezing, mid-conversion reset and the seconds-blanking variant.
module tb_time_frame_builder;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tick;
    logic [4:0]  hours;
    logic [5:0]  minutes;
    logic [5:0]  seconds;
    logic [29:0] pixels;
    logic        busy;
    logic        frame_done;
    logic [29:0] pixels_ns;
    logic        busy_ns;
    logic        frame_done_ns;

    int errors = 0;
    int checks = 0;
    int bc;
    int fd;
    int first_e;
    int second_e;
    logic [29:0] p1;
    logic [29:0] p2;
    logic [29:0] p2ns;

    time_frame_builder #(.edge_start(1'b1), .show_seconds(1'b1)) dut (
        .clk(clk), .rst(rst), .s_tick(s_tick),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .pixels(pixels), .busy(busy), .frame_done(frame_done)
    );

    time_frame_builder #(.edge_start(1'b1), .show_seconds(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .s_tick(s_tick),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .pixels(pixels_ns), .busy(busy_ns), .frame_done(frame_done_ns)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Tick at E0 and advance to just after E19
    task automatic conv(input logic [4:0] h, input logic [5:0] m,
                        input logic [5:0] s);
        hours   = h;
        minutes = m;
        seconds = s;
        s_tick  = 1'b1;
        step(1);
        s_tick  = 1'b0;
        step(19);
    endtask

    initial begin
        rst = 1'b1; s_tick = 1'b1;
        hours = '0; minutes = '0; seconds = '0;
        step(2);
        chk("rst_pixels", 32'(pixels), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fd", 32'(frame_done), 0);

        rst = 1'b0;
        bc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            bc += int'(busy);
        end
        chk("held_tick_busy", bc, 0);
        chk("held_tick_pixels", 32'(pixels), 0);
        s_tick = 1'b0;
        step(1);

        // 12:34:56, minutes changed to 59 after E3
        hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
        s_tick = 1'b1;
        step(1);
        s_tick = 1'b0;
        bc = int'(busy);
        fd = 0;
        for (int e = 1; e <= 18; e++) begin
            step(1);
            bc += int'(busy);
            fd += int'(frame_done);
            if (e == 3) minutes = 6'd59;
        end
        chk("pre_commit_fd", fd, 0);
        chk("pre_commit_pixels", 32'(pixels), 0);
        step(1);
        chk("busy_cycles", bc, 19);
        chk("fd_at_commit", 32'(frame_done), 1);
        chk("busy_after_commit", 32'(busy), 0);
        chk("pix_123456", 32'(pixels), 32'h0C520C41);
        chk("row0", 32'(pixels[4:0]), 1);
        chk("row1", 32'(pixels[9:5]), 2);
        chk("row2", 32'(pixels[14:10]), 3);
        chk("row3", 32'(pixels[19:15]), 4);
        chk("row4", 32'(pixels[24:20]), 5);
        chk("row5", 32'(pixels[29:25]), 6);
        step(1);
        chk("fd_one_cycle", 32'(frame_done), 0);
        chk("ns_123456", 32'(pixels_ns), 32'h00020C41);

        // Out-of-range limits
        conv(5'd31, 6'd63, 6'd0);
        chk("pix_316300", 32'(pixels), 32'h00019823);
        chk("fd_316300", 32'(frame_done), 1);
        step(1);

        // Queued tick at E5, dropped tick at E10
        hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
        s_tick = 1'b1;
        step(1);
        s_tick = 1'b0;
        fd = 0; first_e = 0; second_e = 0;
        p1 = '0; p2 = '0; p2ns = '0;
        for (int e = 1; e <= 40; e++) begin
            step(1);
            if (e == 4)  s_tick = 1'b1;
            if (e == 5)  s_tick = 1'b0;
            if (e == 9)  s_tick = 1'b1;
            if (e == 10) s_tick = 1'b0;
            if (e == 12) begin
                hours = 5'd23; minutes = 6'd59; seconds = 6'd45;
            end
            if (frame_done) begin
                fd++;
                if (fd == 1) begin
                    first_e = e;
                    p1 = pixels;
                end else begin
                    second_e = e;
                    p2 = pixels;
                    p2ns = pixels_ns;
                end
            end
        end
        chk("queued_fd_count", fd, 2);
        chk("first_commit_edge", first_e, 19);
        chk("second_commit_edge", second_e, 38);
        chk("first_frame", 32'(p1), 32'h0C520C41);
        chk("second_frame", 32'(p2), 32'h0A449462);
        chk("ns_second_frame", 32'(p2ns), 32'h00049462);
        chk("idle_after_queue", 32'(busy), 0);

        // Reset at E10 of a conversion
        hours = 5'd31; minutes = 6'd63; seconds = 6'd0;
        s_tick = 1'b1;
        step(1);
        s_tick = 1'b0;
        step(9);
        rst = 1'b1;
        step(1);
        chk("midrst_pixels", 32'(pixels), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_fd", 32'(frame_done), 0);
        rst = 1'b0;
        fd = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            fd += int'(frame_done);
        end
        chk("midrst_no_commit", fd, 0);
        chk("midrst_pixels_hold", 32'(pixels), 0);

        conv(5'd12, 6'd34, 6'd56);
        chk("post_rst_frame", 32'(pixels), 32'h0C520C41);
        chk("post_rst_fd", 32'(frame_done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
